// File: rtl/hqc_pm_arb_pkg.sv
// rtl/hqc_pm_arb_pkg.sv - shared types, parameter-set table and bundle layouts for the poly multiplier arbiter
package hqc_pm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    // parameter-set selectors
    localparam int P_M              = 0;
    localparam int P_LOG_MAX_WEIGHT = 1;
    localparam int P_W_BY_X         = 2;
    localparam int P_ADDR_WIDTH     = 3;
    localparam int P_LOGW           = 4;
    localparam int P_RAMWIDTH       = 5;

    // client-to-multiplier fields, LSB first
    localparam int F_START       = 0;
    localparam int F_LOC_IN      = 1;
    localparam int F_WEIGHT      = 2;
    localparam int F_MUX_WORD_0  = 3;
    localparam int F_MUX_WORD_1  = 4;
    localparam int F_RD_DOUT     = 5;
    localparam int F_ADDR_RESULT = 6;
    localparam int F_ADD_WR_EN   = 7;
    localparam int F_ADD_ADDR    = 8;
    localparam int F_ADD_IN      = 9;
    localparam int F_END         = 10;

    // multiplier-to-client fields, LSB first
    localparam int R_LOC_ADDR = 0;
    localparam int R_DOUT     = 1;
    localparam int R_VALID    = 2;
    localparam int R_ADDR_0   = 3;
    localparam int R_ADDR_1   = 4;
    localparam int R_END      = 5;

    function automatic int ps_index(input logic [47:0] ps);
        if (ps == "hqc192") return 1;
        if (ps == "hqc256") return 2;
        return 0;
    endfunction

    function automatic int pm_param(input logic [47:0] ps, input int p);
        int idx;
        idx = ps_index(ps);
        case (p)
            P_M:              return (idx == 0) ? 15 : 16;
            P_LOG_MAX_WEIGHT: return (idx == 2) ? 8 : 7;
            P_W_BY_X:         return 2;
            P_ADDR_WIDTH:     return (idx == 0) ? 8 : 9;
            P_LOGW:           return 7;
            P_RAMWIDTH:       return 128;
            default:          return 0;
        endcase
    endfunction

    function automatic int fwd_field_w(input logic [47:0] ps, input int f);
        case (f)
            F_START:       return 1;
            F_LOC_IN:      return pm_param(ps, P_M);
            F_WEIGHT:      return pm_param(ps, P_LOG_MAX_WEIGHT);
            F_MUX_WORD_0:  return pm_param(ps, P_RAMWIDTH);
            F_MUX_WORD_1:  return pm_param(ps, P_RAMWIDTH);
            F_RD_DOUT:     return 1;
            F_ADDR_RESULT: return pm_param(ps, P_ADDR_WIDTH);
            F_ADD_WR_EN:   return 1;
            F_ADD_ADDR:    return pm_param(ps, P_ADDR_WIDTH);
            F_ADD_IN:      return pm_param(ps, P_RAMWIDTH);
            default:       return 0;
        endcase
    endfunction

    function automatic int ret_field_w(input logic [47:0] ps, input int f);
        case (f)
            R_LOC_ADDR: return pm_param(ps, P_LOG_MAX_WEIGHT);
            R_DOUT:     return pm_param(ps, P_RAMWIDTH);
            R_VALID:    return 1;
            R_ADDR_0:   return pm_param(ps, P_ADDR_WIDTH);
            R_ADDR_1:   return pm_param(ps, P_ADDR_WIDTH);
            default:    return 0;
        endcase
    endfunction

    function automatic int fwd_off(input logic [47:0] ps, input int f);
        int off;
        off = 0;
        for (int i = 0; i < f; i++) off += fwd_field_w(ps, i);
        return off;
    endfunction

    function automatic int ret_off(input logic [47:0] ps, input int f);
        int off;
        off = 0;
        for (int i = 0; i < f; i++) off += ret_field_w(ps, i);
        return off;
    endfunction

    function automatic int fwd_w(input logic [47:0] ps);
        return fwd_off(ps, F_END);
    endfunction

    function automatic int ret_w(input logic [47:0] ps);
        return ret_off(ps, R_END);
    endfunction

endpackage

// File: rtl/poly_mult_arbiter_mux.sv
// rtl/poly_mult_arbiter_mux.sv - 2:1 bundle select that drives zero when not enabled
module pm_bundle_mux #(
    parameter int W = 8
) (
    input  logic         en,
    input  logic         sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic [W-1:0] out
);

    always_comb begin
        out = '0;
        if (en) out = sel ? in1 : in0;
    end

endmodule

// File: rtl/poly_mult_arbiter.sv
// rtl/poly_mult_arbiter.sv - two-client ownership arbiter in front of a shared HQC poly multiplier
module poly_mult_arbiter
    import hqc_pm_arb_pkg::*;
#(
    parameter logic [47:0] parameter_set = "hqc128",
    parameter int          FWD_W         = fwd_w(parameter_set),
    parameter int          RET_W         = ret_w(parameter_set)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c0_req,
    input  logic             c0_rel,
    output logic             c0_gnt,
    input  logic [FWD_W-1:0] c0_fwd,
    output logic [RET_W-1:0] c0_ret,
    input  logic             c1_req,
    input  logic             c1_rel,
    output logic             c1_gnt,
    input  logic [FWD_W-1:0] c1_fwd,
    output logic [RET_W-1:0] c1_ret,
    output logic [FWD_W-1:0] pm_fwd,
    input  logic [RET_W-1:0] pm_ret,
    output logic             err
);

    localparam int START_BIT = fwd_off(parameter_set, F_START);
    localparam int WR_EN_BIT = fwd_off(parameter_set, F_ADD_WR_EN);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;
    logic       err_q, err_d;
    logic       busy;
    logic       own_req, own_rel;
    logic       c0_drives, c1_drives;

    assign busy    = (state_q == ST_BUSY);
    assign c0_gnt  = busy & ~owner_q;
    assign c1_gnt  = busy & owner_q;
    assign own_req = owner_q ? c1_req : c0_req;
    assign own_rel = owner_q ? c1_rel : c0_rel;

    // a client touching start or the adder write strobe without ownership is a protocol error
    assign c0_drives = c0_fwd[START_BIT] | c0_fwd[WR_EN_BIT];
    assign c1_drives = c1_fwd[START_BIT] | c1_fwd[WR_EN_BIT];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        err_d        = err_q | (c0_drives & ~c0_gnt) | (c1_drives & ~c1_gnt);
        case (state_q)
            ST_IDLE: begin
                if (c0_req | c1_req) begin
                    state_d = ST_BUSY;
                    owner_d = (c0_req & c1_req) ? ~last_owner_q : c1_req;
                end
            end
            ST_BUSY: begin
                if (own_rel | ~own_req) begin
                    state_d      = ST_DRAIN;
                    last_owner_d = owner_q;
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            err_q        <= err_d;
        end
    end

    assign err = err_q;

    pm_bundle_mux #(
        .W (FWD_W)
    ) u_fwd_mux (
        .en  (busy),
        .sel (owner_q),
        .in0 (c0_fwd),
        .in1 (c1_fwd),
        .out (pm_fwd)
    );

    assign c0_ret = c0_gnt ? pm_ret : '0;
    assign c1_ret = c1_gnt ? pm_ret : '0;

endmodule

// File: tb/tb_poly_mult_arbiter.sv
// tb/tb_poly_mult_arbiter.sv - self-checking bench for poly_mult_arbiter
module tb_poly_mult_arbiter;
    import hqc_pm_arb_pkg::*;

    localparam logic [47:0] PS    = "hqc128";
    localparam int          FWD_W = fwd_w(PS);
    localparam int          RET_W = ret_w(PS);
    localparam int          START_B = fwd_off(PS, F_START);
    localparam int          WR_B    = fwd_off(PS, F_ADD_WR_EN);
    localparam int          VALID_B = ret_off(PS, R_VALID);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             c0_req = 1'b0, c0_rel = 1'b0, c1_req = 1'b0, c1_rel = 1'b0;
    logic             c0_gnt, c1_gnt, err;
    logic [FWD_W-1:0] c0_fwd = '0, c1_fwd = '0, pm_fwd;
    logic [RET_W-1:0] c0_ret, c1_ret, pm_ret = '0;

    int errors = 0;
    int checks = 0;

    poly_mult_arbiter #(
        .parameter_set (PS),
        .FWD_W         (FWD_W),
        .RET_W         (RET_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .c0_req (c0_req),
        .c0_rel (c0_rel),
        .c0_gnt (c0_gnt),
        .c0_fwd (c0_fwd),
        .c0_ret (c0_ret),
        .c1_req (c1_req),
        .c1_rel (c1_rel),
        .c1_gnt (c1_gnt),
        .c1_fwd (c1_fwd),
        .c1_ret (c1_ret),
        .pm_fwd (pm_fwd),
        .pm_ret (pm_ret),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [FWD_W-1:0] rand_fwd(input bit start, input bit wr);
        logic [511:0] t;
        for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
        rand_fwd = t[FWD_W-1:0];
        rand_fwd[START_B] = start;
        rand_fwd[WR_B]    = wr;
    endfunction

    function automatic logic [RET_W-1:0] rand_ret(input bit valid);
        logic [511:0] t;
        for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
        rand_ret = t[RET_W-1:0];
        rand_ret[VALID_B] = valid;
    endfunction

    // Reference: who holds the multiplier, how many idle-gap cycles remain before
    // the next arbitration, who held it last, and the sticky error.
    int               m_owner = -1;
    int               m_gap   = 0;
    int               m_last  = 1;
    bit               m_err   = 1'b0;
    logic [FWD_W-1:0] e_fwd;
    logic [RET_W-1:0] e_ret0, e_ret1;
    bit               r0, r1;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_fwd  = (m_owner == 0) ? c0_fwd : (m_owner == 1) ? c1_fwd : '0;
            e_ret0 = (m_owner == 0) ? pm_ret : '0;
            e_ret1 = (m_owner == 1) ? pm_ret : '0;
            chk("c0_gnt", c0_gnt, m_owner == 0);
            chk("c1_gnt", c1_gnt, m_owner == 1);
            chk("gnt_exclusive", c0_gnt & c1_gnt, 1'b0);
            chk("pm_fwd", pm_fwd, e_fwd);
            chk("c0_ret", c0_ret, e_ret0);
            chk("c1_ret", c1_ret, e_ret1);
            chk("err", err, m_err);
            if (rst) begin
                m_owner = -1; m_gap = 0; m_last = 1; m_err = 1'b0;
            end else begin
                if ((c0_fwd[START_B] || c0_fwd[WR_B]) && m_owner != 0) m_err = 1'b1;
                if ((c1_fwd[START_B] || c1_fwd[WR_B]) && m_owner != 1) m_err = 1'b1;
                if (m_owner >= 0) begin
                    r0 = (m_owner == 0) ? c0_rel : c1_rel;
                    r1 = (m_owner == 0) ? c0_req : c1_req;
                    if (r0 || !r1) begin
                        m_last = m_owner; m_owner = -1; m_gap = 1;
                    end
                end else if (m_gap > 0) begin
                    m_gap--;
                end else if (c0_req || c1_req) begin
                    m_owner = (c0_req && c1_req) ? 1 - m_last : (c1_req ? 1 : 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        c0_req = 0; c0_rel = 0; c1_req = 0; c1_rel = 0;
        c0_fwd = '0; c1_fwd = '0; pm_ret = '0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [FWD_W-1:0] f0, f1;
    logic [RET_W-1:0] rr;
    int               order[$];
    int               first_c1;
    int               cnt0, cnt1;
    bit               p0, p1;

    initial begin
        reset_dut();
        #2;
        chk("reset_c0_gnt", c0_gnt, 1'b0);
        chk("reset_c1_gnt", c1_gnt, 1'b0);
        chk("reset_pm_fwd", pm_fwd, '0);
        chk("reset_err", err, 1'b0);

        // lone request: grant one cycle later, forward path and return routing
        tick();
        c0_req = 1;
        #2 chk("t029_gnt_c0", c0_gnt, 1'b0);
        tick();
        f0 = rand_fwd(1, 0);
        rr = rand_ret(1);
        c0_fwd = f0; pm_ret = rr;
        #2;
        chk("t029_gnt_c1", c0_gnt, 1'b1);
        chk("t029_pm_fwd", pm_fwd, f0);
        chk("t029_pm_start", pm_fwd[START_B], 1'b1);
        chk("t029_c0_ret", c0_ret, rr);
        chk("t029_c1_ret", c1_ret, '0);
        tick();
        c0_req = 0; c0_fwd = '0;
        tick(); tick(); tick();

        // tie after reset, c0 releases at cycle 10
        reset_dut();
        for (int c = 0; c < 15; c++) begin
            c0_req = 1; c1_req = 1;
            c0_rel = (c == 10);
            #2;
            chk("t030_c0_gnt", c0_gnt, (c >= 1 && c <= 10));
            chk("t030_c1_gnt", c1_gnt, (c >= 13));
            tick();
        end
        clear_inputs();
        tick(); tick(); tick();

        // continuous contention, five owned cycles each
        reset_dut();
        c0_req = 1; c1_req = 1;
        cnt0 = 0; cnt1 = 0; p0 = 0; p1 = 0; first_c1 = -1;
        order.delete();
        for (int c = 0; c < 40; c++) begin
            if (c0_gnt) cnt0++; else cnt0 = 0;
            if (c1_gnt) cnt1++; else cnt1 = 0;
            c0_rel = (cnt0 == 5);
            c1_rel = (cnt1 == 5);
            if (c0_gnt && !p0) order.push_back(0);
            if (c1_gnt && !p1) begin
                order.push_back(1);
                if (first_c1 < 0) first_c1 = c;
            end
            p0 = c0_gnt; p1 = c1_gnt;
            tick();
        end
        chk("t031_grants", order.size() >= 4, 1'b1);
        if (order.size() >= 4)
            for (int i = 0; i < 4; i++) chk("t031_order", order[i], i % 2);
        chk("t031_first_c1_cycle", first_c1, 8);
        clear_inputs();
        tick(); tick(); tick();

        // non-owner start sets sticky err; reset mid-BUSY clears everything
        reset_dut();
        c0_req = 1;
        tick();
        f0 = rand_fwd(1, 1);
        c0_fwd = f0;
        tick();
        f1 = rand_fwd(1, 0);
        c1_fwd = f1;
        #2;
        chk("t032_pm_fwd", pm_fwd, f0);
        chk("t032_err_pre", err, 1'b0);
        tick();
        c1_fwd = '0;
        #2 chk("t032_err_set", err, 1'b1);
        tick();
        c0_req = 0; c0_fwd = '0; c1_req = 1;
        tick(); tick(); tick();
        #2;
        chk("t032_c1_owns", c1_gnt, 1'b1);
        chk("t032_err_held", err, 1'b1);
        tick();
        rst = 1; c0_req = 1; c1_req = 1;
        tick();
        rst = 0;
        #2;
        chk("t033_c0_gnt", c0_gnt, 1'b0);
        chk("t033_c1_gnt", c1_gnt, 1'b0);
        chk("t033_pm_fwd", pm_fwd, '0);
        chk("t033_err", err, 1'b0);
        tick();
        #2 chk("t033_c0_wins", c0_gnt, 1'b1);
        clear_inputs();
        tick(); tick(); tick();

        // release from the non-owner is ignored
        reset_dut();
        c0_req = 1;
        tick();
        rr = rand_ret(1);
        pm_ret = rr; c1_rel = 1;
        #2;
        chk("t034_c0_ret", c0_ret, rr);
        chk("t034_c1_ret", c1_ret, '0);
        tick();
        c1_rel = 0;
        #2 chk("t034_still_owner", c0_gnt, 1'b1);
        clear_inputs();
        tick(); tick(); tick();

        // randomized traffic checked by the reference every cycle
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) c0_req = ~c0_req;
            if ($urandom_range(0, 7) == 0) c1_req = ~c1_req;
            c0_rel = ($urandom_range(0, 5) == 0);
            c1_rel = ($urandom_range(0, 5) == 0);
            c0_fwd = rand_fwd((m_owner == 0) ? $urandom_range(0, 1) : ($urandom_range(0, 99) == 0),
                              (m_owner == 0) ? $urandom_range(0, 1) : 1'b0);
            c1_fwd = rand_fwd((m_owner == 1) ? $urandom_range(0, 1) : ($urandom_range(0, 99) == 0),
                              (m_owner == 1) ? $urandom_range(0, 1) : 1'b0);
            pm_ret = rand_ret($urandom_range(0, 1));
            tick();
        end
        rst = 0;
        clear_inputs();
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
